// File: rtl/demux_1ton_reg_pkg.sv
// demux_pkg: shared helpers for the registered 1:N demultiplexer.
//   sel_w(n)      : select width for n channels ($clog2(n), never below 1)
//   DEMUX_IDLE    : inactive level for strobes and reset values
//   DEMUX_SLOT_T  : macro yielding the per-channel slot record {valid, data}
//                   for a given data width (packages cannot hold
//                   parametrised types)
// Optional feature macro used elsewhere in the slice: DEMUX_ERR_EN.

`ifndef DEMUX_PKG_SV
`define DEMUX_PKG_SV

`define DEMUX_SLOT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package demux_pkg;

  localparam logic DEMUX_IDLE = '0;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/demux_1ton_reg_if.sv
// demux_1ton_reg_if: upstream word/select handshake plus the per-channel
// output slots of demux_1ton_reg.
//   inData/inSel/inValid : source word, destination, qualifier
//   outReady             : block accepts (or drops) the word this cycle
//   outData/outValid     : channel k data at [k*DATA_W +: DATA_W]
//   inChReady            : per-channel downstream ready
//   outErr/outErrSel     : sticky out-of-range flag and captured select
//                          (present only with DEMUX_ERR_EN defined)
// master = source/consumer side, slave = demux side.

interface demux_1ton_reg_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4
);
  localparam int SEL_W = sel_w(N_CH);

  logic [DATA_W-1:0]      inData;
  logic [SEL_W-1:0]       inSel;
  logic                   inValid;
  logic                   outReady;
  logic [N_CH*DATA_W-1:0] outData;
  logic [N_CH-1:0]        outValid;
  logic [N_CH-1:0]        inChReady;
`ifdef DEMUX_ERR_EN
  logic                   outErr;
  logic [SEL_W-1:0]       outErrSel;

  modport master (
    output inData, inSel, inValid, inChReady,
    input  outReady, outData, outValid, outErr, outErrSel
  );
  modport slave (
    input  inData, inSel, inValid, inChReady,
    output outReady, outData, outValid, outErr, outErrSel
  );
`else
  modport master (
    output inData, inSel, inValid, inChReady,
    input  outReady, outData, outValid
  );
  modport slave (
    input  inData, inSel, inValid, inChReady,
    output outReady, outData, outValid
  );
`endif

endinterface

// File: rtl/demux_1ton_reg_slot.sv
// demux_slot: 1-deep register stage for one demux output channel.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr, wdata   : load a new word at the next edge
//   rd_ready    : downstream takes the held word this cycle
//   valid, data : held word; data keeps its last value after a drain
//   can_accept  : slot is empty or draining this cycle

module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              can_accept
);

  typedef `DEMUX_SLOT_T(DATA_W) slot_t;

  slot_t slot_q, slot_d;

  // A write in the same cycle as a drain wins, so valid stays high.
  always_comb begin
    slot_d = slot_q;
    if (slot_q.valid && rd_ready) slot_d.valid = DEMUX_IDLE;
    if (wr) begin
      slot_d.valid = 1'b1;
      slot_d.data  = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign valid      = slot_q.valid;
  assign data       = slot_q.data;
  assign can_accept = ~slot_q.valid | rd_ready;

endmodule

// File: rtl/demux_1ton_reg.sv
// demux_1ton_reg: registered 1:N demultiplexer with valid/ready flow control.
// Routes a DATA_W-bit word to one of N_CH one-deep channel slots chosen by
// inSel; a stalled channel never blocks traffic to the other channels.
//   inClock : rising-edge clock
//   inReset : synchronous active-low reset
//   bus     : demux_1ton_reg_if slave modport (word, select, handshakes,
//             per-channel slots; outErr/outErrSel with DEMUX_ERR_EN)
// Build option DEMUX_ERR_EN: adds a sticky flag and captured select for
// the first accepted out-of-range word. Without it such words are dropped
// silently.

module demux_1ton_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4
) (
  input  logic            inClock,
  input  logic            inReset,
  demux_1ton_reg_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);
  localparam logic [SEL_W:0] N_CH_EXT = (SEL_W+1)'(N_CH);

  logic                   sel_ok;
  logic                   ready;
  logic                   xfer;
  logic [N_CH-1:0]        wr;
  logic [N_CH-1:0]        can_accept;
  logic [N_CH-1:0]        slot_valid;
  logic [DATA_W-1:0]      slot_data [N_CH];
  logic [N_CH*DATA_W-1:0] data_flat;

  // Out-of-range selects are always accepted, and then dropped.
  always_comb begin
    sel_ok = ({1'b0, bus.inSel} < N_CH_EXT);
    ready  = 1'b1;
    if (sel_ok) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (bus.inSel == SEL_W'(k)) ready = can_accept[k];
      end
    end
    xfer = bus.inValid & ready;
    wr   = {N_CH{DEMUX_IDLE}};
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (xfer && sel_ok && bus.inSel == SEL_W'(k)) wr[k] = 1'b1;
    end
    data_flat = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      data_flat[k*DATA_W +: DATA_W] = slot_data[k];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (inClock),
      .rst_n      (inReset),
      .wr         (wr[k]),
      .wdata      (bus.inData),
      .rd_ready   (bus.inChReady[k]),
      .valid      (slot_valid[k]),
      .data       (slot_data[k]),
      .can_accept (can_accept[k])
    );
  end

  assign bus.outReady = ready;
  assign bus.outData  = data_flat;
  assign bus.outValid = slot_valid;

`ifdef DEMUX_ERR_EN
  logic             err_q, err_d;
  logic [SEL_W-1:0] err_sel_q, err_sel_d;

  // Only the first offending select is kept; later ones leave it alone.
  always_comb begin
    err_d     = err_q;
    err_sel_d = err_sel_q;
    if (xfer && !sel_ok && !err_q) begin
      err_d     = 1'b1;
      err_sel_d = bus.inSel;
    end
  end

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      err_q     <= DEMUX_IDLE;
      err_sel_q <= '0;
    end else begin
      err_q     <= err_d;
      err_sel_q <= err_sel_d;
    end
  end

  assign bus.outErr    = err_q;
  assign bus.outErrSel = err_sel_q;
`endif

endmodule

// File: tb/tb_demux_1ton_reg.sv
// tb_demux_1ton_reg: directed bench for demux_1ton_reg with a 4-channel
// instance (reset, routing, backpressure, independence, mid-run reset) and
// a 5-channel instance (out-of-range select; error flag with DEMUX_ERR_EN).

`timescale 1ns/1ps

module tb_demux_1ton_reg;

  logic inClock = 1'b0;
  logic inReset;

  always #5 inClock = ~inClock;

  demux_1ton_reg_if #(.DATA_W(8), .N_CH(4)) if4 ();
  demux_1ton_reg_if #(.DATA_W(8), .N_CH(5)) if5 ();

  demux_1ton_reg #(.DATA_W(8), .N_CH(4)) u_dut4 (
    .inClock (inClock),
    .inReset (inReset),
    .bus     (if4)
  );

  demux_1ton_reg #(.DATA_W(8), .N_CH(5)) u_dut5 (
    .inClock (inClock),
    .inReset (inReset),
    .bus     (if5)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge inClock);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [1:0] s, input logic [7:0] d);
    if4.inValid = v;
    if4.inSel   = s;
    if4.inData  = d;
    #1;
  endtask

  task automatic drive5(input logic v, input logic [2:0] s, input logic [7:0] d);
    if5.inValid = v;
    if5.inSel   = s;
    if5.inData  = d;
    #1;
  endtask

  initial begin
    inReset       = 1'b0;
    if4.inChReady = 4'hF;
    if5.inChReady = 5'h1F;
    drive5(1'b0, 3'd0, 8'h00);

    // Reset held 3 cycles while the source presents a valid word.
    drive4(1'b1, 2'd0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", 64'(if4.outValid), 64'h0);
      check("rst_data",  64'(if4.outData),  64'h0);
    end
    inReset = 1'b1;
    #1;
    step();
    check("post_rst_valid", 64'(if4.outValid), 64'h1);
    check("post_rst_data",  64'(if4.outData),  64'h0000_00FF);
    drive4(1'b0, 2'd0, 8'h00);
    step();
    check("drain_valid", 64'(if4.outValid), 64'h0);
    check("drain_keep",  64'(if4.outData),  64'h0000_00FF);

    // Routing to channel 2.
    drive4(1'b1, 2'd2, 8'hA5);
    check("route_ready", 64'(if4.outReady), 64'h1);
    step();
    check("route_valid", 64'(if4.outValid), 64'h4);
    check("route_data",  64'(if4.outData),  64'h00A5_00FF);
    drive4(1'b0, 2'd0, 8'h00);
    step();
    check("route_drain", 64'(if4.outValid), 64'h0);

    // Backpressure on channel 1.
    if4.inChReady = 4'b1101;
    drive4(1'b1, 2'd1, 8'h11);
    check("bp_ready1", 64'(if4.outReady), 64'h1);
    step();
    check("bp_valid1", 64'(if4.outValid), 64'h2);
    check("bp_data1",  64'(if4.outData),  64'h00A5_11FF);
    drive4(1'b1, 2'd1, 8'h22);
    check("bp_stall", 64'(if4.outReady), 64'h0);
    step();
    check("bp_hold_valid", 64'(if4.outValid), 64'h2);
    check("bp_hold_data",  64'(if4.outData),  64'h00A5_11FF);
    check("bp_stall2",     64'(if4.outReady), 64'h0);
    if4.inChReady = 4'hF;
    #1;
    check("bp_release", 64'(if4.outReady), 64'h1);
    step();
    check("bp_swap_valid", 64'(if4.outValid), 64'h2);
    check("bp_swap_data",  64'(if4.outData),  64'h00A5_22FF);
    drive4(1'b0, 2'd0, 8'h00);
    step();
    check("bp_final_valid", 64'(if4.outValid), 64'h0);
    check("bp_final_data",  64'(if4.outData),  64'h00A5_22FF);

    // Channel 0 full and stalled while channel 3 streams at full rate.
    if4.inChReady = 4'b1110;
    drive4(1'b1, 2'd0, 8'h44);
    step();
    check("ind_fill", 64'(if4.outValid), 64'h1);
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 2'd3, 8'(8'h30 + i));
      check("ind_ready", 64'(if4.outReady), 64'h1);
      step();
      check("ind_valid", 64'(if4.outValid), 64'h9);
      check("ind_data",  64'(if4.outData[31:24]), 64'(8'h30 + i));
    end
    drive4(1'b0, 2'd0, 8'h00);
    step();
    check("ind_end_valid", 64'(if4.outValid), 64'h1);
    check("ind_end_data",  64'(if4.outData),  64'h37A5_2244);

    // All four slots full, then reset for one cycle.
    if4.inChReady = 4'h0;
    drive4(1'b1, 2'd1, 8'h51);
    step();
    drive4(1'b1, 2'd2, 8'h52);
    step();
    drive4(1'b1, 2'd3, 8'h53);
    step();
    check("full_valid", 64'(if4.outValid), 64'hF);
    check("full_data",  64'(if4.outData),  64'h5352_5144);
    drive4(1'b1, 2'd0, 8'h99);
    check("full_stall", 64'(if4.outReady), 64'h0);
    drive4(1'b0, 2'd0, 8'h00);
    inReset = 1'b0;
    step();
    check("mid_rst_valid", 64'(if4.outValid), 64'h0);
    check("mid_rst_data",  64'(if4.outData),  64'h0);
    inReset = 1'b1;
    step();
    check("after_rst_valid", 64'(if4.outValid), 64'h0);
    check("after_rst_data",  64'(if4.outData),  64'h0);
    drive4(1'b1, 2'd2, 8'h66);
    step();
    check("after_rst_wr_valid", 64'(if4.outValid), 64'h4);
    check("after_rst_wr_data",  64'(if4.outData),  64'h0066_0000);
    drive4(1'b0, 2'd0, 8'h00);

    // Five channels: top in-range select, then out-of-range selects.
`ifdef DEMUX_ERR_EN
    check("err_init", 64'(if5.outErr), 64'h0);
`endif
    drive5(1'b1, 3'd4, 8'h99);
    check("n5_ready4", 64'(if5.outReady), 64'h1);
    step();
    check("n5_valid4", 64'(if5.outValid), 64'h10);
    check("n5_data4",  64'(if5.outData),  64'h99_0000_0000);
    drive5(1'b0, 3'd0, 8'h00);
    step();
    check("n5_drain4", 64'(if5.outValid), 64'h0);
    drive5(1'b1, 3'd6, 8'h77);
    check("oor_ready", 64'(if5.outReady), 64'h1);
    step();
    check("oor_valid", 64'(if5.outValid), 64'h0);
    check("oor_data",  64'(if5.outData),  64'h99_0000_0000);
`ifdef DEMUX_ERR_EN
    check("err_set", 64'(if5.outErr),    64'h1);
    check("err_sel", 64'(if5.outErrSel), 64'h6);
`endif
    drive5(1'b1, 3'd5, 8'h78);
    check("oor_ready5", 64'(if5.outReady), 64'h1);
    step();
    check("oor_valid5", 64'(if5.outValid), 64'h0);
`ifdef DEMUX_ERR_EN
    check("err_sticky",     64'(if5.outErr),    64'h1);
    check("err_sel_sticky", 64'(if5.outErrSel), 64'h6);
`endif
    drive5(1'b0, 3'd0, 8'h00);
    inReset = 1'b0;
    step();
    inReset = 1'b1;
    check("n5_rst_data", 64'(if5.outData), 64'h0);
`ifdef DEMUX_ERR_EN
    check("err_rst",     64'(if5.outErr),    64'h0);
    check("err_sel_rst", 64'(if5.outErrSel), 64'h0);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
